slave_resp: RTL and testbench

Slave-side responder for the two-slave valid/ready write interconnect. It accepts one write transaction at a time: the 3-bit value is written into an 8-entry × 3-bit register file at a 3-bit address. Ready is asserted after a programmable delay to emulate slave latency. Two instances sit downstream of the interconnect, one per slave port, and give benches and downstream logic a checkable end point (readback port, completion pulse, write counter).

---
 rtl/slave_resp_pkg.sv | 16 +
 rtl/slave_regfile.sv | 32 +++
 rtl/slave_resp.sv | 128 ++++++++++++
 tb/tb_slave_resp.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slave_resp_pkg.sv
// Shared types and sizes for the slave-side write responder.
package slave_resp_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 3;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck,
    StRecover
  } state_e;

endpackage

// File: rtl/slave_regfile.sv
// 8x3 register file: one synchronous write port, one registered read-before-write read port.
module slave_regfile
  import slave_resp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DATA_W-1:0]            rdata_q;

  // Non-blocking read of mem_q returns the pre-write contents on a same-entry collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (we) begin
        mem_q[waddr] <= wdata;
      end
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/slave_resp.sv
// Slave responder: delayed-ready handshake, register file write, completion pulse and counter.
// Optional overwrite detection is enabled by defining SLAVE_RESP_OVERWRITE_DET_EN.
module slave_resp
  import slave_resp_pkg::*;
#(
  parameter int unsigned READY_DELAY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] value,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              ready,
  output logic              wr_done,
  output logic [DATA_W-1:0] rd_data,
  output logic [7:0]        wr_count,
  output logic              busy,
  output logic              overwrite
);

  localparam logic [CNT_W-1:0] CntLoad = (READY_DELAY > 1) ? CNT_W'(READY_DELAY - 2) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             wr_done_q;
  logic [7:0]       wr_count_q;
  logic             we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid) begin
          if (READY_DELAY == 1) begin
            state_d = StAck;
            ready_d = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntLoad;
          end
        end
      end
      StWait: begin
        if (!valid) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StAck;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAck: begin
        if (valid && ready_q) begin
          we      = 1'b1;
          ready_d = 1'b0;
          state_d = StRecover;
        end else if (!valid) begin
          ready_d = 1'b0;
          state_d = StIdle;
        end
      end
      // One dead cycle so the master's held-over valid is never taken as a new request.
      StRecover: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      wr_done_q  <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      wr_done_q <= we;
      if (we) begin
        wr_count_q <= wr_count_q + 8'd1;
      end
    end
  end

  slave_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (addr),
    .wdata (value),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef SLAVE_RESP_OVERWRITE_DET_EN
  logic [DEPTH-1:0] flags_q;
  logic             overwrite_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q     <= '0;
      overwrite_q <= 1'b0;
    end else begin
      overwrite_q <= we & flags_q[addr];
      if (we) begin
        flags_q[addr] <= 1'b1;
      end
    end
  end

  assign overwrite = overwrite_q;
`else
  assign overwrite = 1'b0;
`endif

  assign ready    = ready_q;
  assign wr_done  = wr_done_q;
  assign wr_count = wr_count_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_slave_resp.sv
// Bench for slave_resp: three instances (READY_DELAY 1, 2, 4) checked against a transaction model.
module tb_slave_resp;

  logic            clk;
  logic            rst_n;
  logic [2:0]      valid;
  logic [2:0][2:0] addr, value, rd_addr, rd_data;
  logic [2:0]      ready, wr_done, busy, ovw;
  logic [2:0][7:0] wr_count;

  int vectors = 0;
  int miscompares = 0;

  int         dly [3] = '{1, 2, 4};
  logic [2:0] mem_m [3][8];
  logic       flag_m [3][8];
  int         count_m [3];

  slave_resp #(.READY_DELAY(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .valid(valid[0]), .addr(addr[0]), .value(value[0]),
    .rd_addr(rd_addr[0]), .ready(ready[0]), .wr_done(wr_done[0]), .rd_data(rd_data[0]),
    .wr_count(wr_count[0]), .busy(busy[0]), .overwrite(ovw[0])
  );
  slave_resp #(.READY_DELAY(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .valid(valid[1]), .addr(addr[1]), .value(value[1]),
    .rd_addr(rd_addr[1]), .ready(ready[1]), .wr_done(wr_done[1]), .rd_data(rd_data[1]),
    .wr_count(wr_count[1]), .busy(busy[1]), .overwrite(ovw[1])
  );
  slave_resp #(.READY_DELAY(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .valid(valid[2]), .addr(addr[2]), .value(value[2]),
    .rd_addr(rd_addr[2]), .ready(ready[2]), .wr_done(wr_done[2]), .rd_data(rd_data[2]),
    .wr_count(wr_count[2]), .busy(busy[2]), .overwrite(ovw[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      count_m[i] = 0;
      for (int a = 0; a < 8; a++) begin
        mem_m[i][a]  = '0;
        flag_m[i][a] = 1'b0;
      end
    end
  endtask

  // One complete write on instance i; returns at the wr_done cycle with valid still held high.
  task automatic txn(input int i, input logic [2:0] a, input logic [2:0] v,
                     input logic [2:0] ra);
    logic [2:0] exp_rd;
    logic       exp_ov;
    @(negedge clk);
    valid      = '0;
    valid[i]   = 1'b1;
    addr[i]    = a;
    value[i]   = v;
    rd_addr[i] = ra;
    vectors++;
    if (busy[i] !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_busy inst%0d: got %b want 0", i, busy[i]);
    end
    for (int j = 1; j <= dly[i]; j++) begin
      @(negedge clk);
      vectors++;
      if (ready[i] !== ((j == dly[i]) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL ready_delay inst%0d cyc%0d: got %b want %b", i, j, ready[i], j == dly[i]);
      end
      vectors++;
      if (busy[i] !== 1'b1 || wr_done[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL wait_flags inst%0d cyc%0d: busy %b wr_done %b want 1 0",
                 i, j, busy[i], wr_done[i]);
      end
    end
    exp_rd = mem_m[i][ra];
`ifdef SLAVE_RESP_OVERWRITE_DET_EN
    exp_ov = flag_m[i][a];
`else
    exp_ov = 1'b0;
`endif
    mem_m[i][a]  = v;
    flag_m[i][a] = 1'b1;
    count_m[i]   = (count_m[i] + 1) % 256;
    @(negedge clk);
    vectors++;
    if (wr_done[i] !== 1'b1 || ready[i] !== 1'b0 || busy[i] !== 1'b1) begin
      miscompares++;
      $display("FAIL recover_flags inst%0d: wr_done %b ready %b busy %b want 1 0 1",
               i, wr_done[i], ready[i], busy[i]);
    end
    vectors++;
    if (wr_count[i] !== 8'(count_m[i])) begin
      miscompares++;
      $display("FAIL wr_count inst%0d: got %0d want %0d", i, wr_count[i], count_m[i]);
    end
    vectors++;
    if (rd_data[i] !== exp_rd) begin
      miscompares++;
      $display("FAIL rd_old inst%0d: got %0d want %0d", i, rd_data[i], exp_rd);
    end
    vectors++;
    if (ovw[i] !== exp_ov) begin
      miscompares++;
      $display("FAIL overwrite inst%0d addr%0d: got %b want %b", i, a, ovw[i], exp_ov);
    end
  endtask

  task automatic rd(input int i, input logic [2:0] a);
    @(negedge clk);
    valid[i]   = 1'b0;
    rd_addr[i] = a;
    @(negedge clk);
    vectors++;
    if (rd_data[i] !== mem_m[i][a]) begin
      miscompares++;
      $display("FAIL readback inst%0d addr%0d: got %0d want %0d", i, a, rd_data[i], mem_m[i][a]);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    valid   = '0;
    addr    = '0;
    value   = '0;
    rd_addr = '0;
    reset_model();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({ready[i], wr_done[i], busy[i], ovw[i], rd_data[i], wr_count[i]} !== 15'd0) begin
        miscompares++;
        $display("FAIL reset_state inst%0d: got %b%b%b%b %0d %0d want all 0",
                 i, ready[i], wr_done[i], busy[i], ovw[i], rd_data[i], wr_count[i]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    txn(1, 3'd5, 3'd6, 3'd5);
    rd(1, 3'd5);
  endtask

  task automatic test_back_to_back();
    txn(0, 3'd1, 3'd2, 3'd1);
    txn(0, 3'd2, 3'd5, 3'd2);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (wr_count[0] !== 8'(count_m[0]) || ready[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_extra inst0: wr_count %0d ready %b want %0d 0",
                 wr_count[0], ready[0], count_m[0]);
      end
    end
    rd(0, 3'd1);
    rd(0, 3'd2);
  endtask

  task automatic test_withdraw();
    @(negedge clk);
    valid      = '0;
    valid[2]   = 1'b1;
    addr[2]    = 3'd4;
    value[2]   = 3'd5;
    rd_addr[2] = 3'd4;
    @(negedge clk);
    @(negedge clk);
    valid[2] = 1'b0;
    repeat (6) begin
      vectors++;
      if (ready[2] !== 1'b0) begin
        miscompares++;
        $display("FAIL withdraw_ready inst2: got %b want 0", ready[2]);
      end
      @(negedge clk);
    end
    vectors++;
    if (busy[2] !== 1'b0 || wr_count[2] !== 8'(count_m[2]) || rd_data[2] !== mem_m[2][4]) begin
      miscompares++;
      $display("FAIL withdraw_state inst2: busy %b wr_count %0d rd_data %0d want 0 %0d %0d",
               busy[2], wr_count[2], rd_data[2], count_m[2], mem_m[2][4]);
    end
  endtask

  task automatic test_reset_in_ack();
    int n;
    @(negedge clk);
    valid      = '0;
    valid[1]   = 1'b1;
    addr[1]    = 3'd6;
    value[1]   = 3'd7;
    rd_addr[1] = 3'd6;
    n = 0;
    while (ready[1] !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (ready[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL ack_reach inst1: ready %b want 1 within 10 cycles", ready[1]);
    end
    rst_n = 1'b0;
    reset_model();
    #1;
    vectors++;
    if (ready[1] !== 1'b0 || busy[1] !== 1'b0 || wr_count[1] !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_abort inst1: ready %b busy %b wr_count %0d want 0 0 0",
               ready[1], busy[1], wr_count[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rd(1, 3'd6);
    vectors++;
    if (wr_count[1] !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_count inst1: got %0d want 0", wr_count[1]);
    end
  endtask

  task automatic test_overwrite();
    txn(0, 3'd3, 3'd1, 3'd0);
    txn(0, 3'd2, 3'd4, 3'd0);
    txn(0, 3'd2, 3'd7, 3'd0);
    rd(0, 3'd2);
  endtask

  task automatic test_read_before_write();
    txn(1, 3'd7, 3'd1, 3'd0);
    txn(1, 3'd7, 3'd3, 3'd7);
    @(negedge clk);
    valid[1] = 1'b0;
    vectors++;
    if (rd_data[1] !== 3'd3) begin
      miscompares++;
      $display("FAIL rbw_new inst1: got %0d want 3", rd_data[1]);
    end
  endtask

  task automatic test_wrap();
    int n;
    n = 256 - count_m[0];
    for (int k = 0; k < n; k++) begin
      txn(0, 3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)));
    end
    @(negedge clk);
    valid[0] = 1'b0;
    vectors++;
    if (wr_count[0] !== 8'd0) begin
      miscompares++;
      $display("FAIL wrap inst0: got %0d want 0", wr_count[0]);
    end
  endtask

  task automatic test_random();
    int i;
    for (int k = 0; k < 40; k++) begin
      i = int'($urandom_range(2));
      txn(i, 3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)));
      repeat ($urandom_range(2)) begin
        @(negedge clk);
        valid = '0;
      end
    end
    for (int j = 0; j < 3; j++) begin
      for (int a = 0; a < 8; a++) begin
        rd(j, 3'(a));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_withdraw();
    test_reset_in_ack();
    test_overwrite();
    test_read_before_write();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
